// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter, dmem_arb_pick).
// Optional round-robin contention is selected with DMEM_ARB_RR_EN.
package dmem_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    // Keeps the starvation counter at least one bit wide even for STARVE_MAX = 0.
    function automatic int starve_cnt_w(input int starve_max);
        return (starve_max < 1) ? 1 : $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the core (port 0) and loader (port 1).
// DMEM_ARB_RR_EN selects round-robin contention; otherwise port 0 wins unless starve_hit.
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic en,
    input  logic p0_req,
    input  logic p1_req,
`ifdef DMEM_ARB_RR_EN
    input  logic rr_ptr,
`else
    input  logic starve_hit,
`endif
    output logic p0_gnt,
    output logic p1_gnt,
    output logic winner
);

    logic contend;
    logic prefer;

    always_comb begin
        contend = p0_req && p1_req;
`ifdef DMEM_ARB_RR_EN
        prefer = rr_ptr;
`else
        prefer = starve_hit ? PORT_LOADER : PORT_CORE;
`endif
        winner = PORT_CORE;
        if (contend) begin
            winner = prefer;
        end else if (p1_req) begin
            winner = PORT_LOADER;
        end
        // Grants are suppressed while reset is held.
        p0_gnt = en && p0_req && (winner == PORT_CORE);
        p1_gnt = en && p1_req && (winner == PORT_LOADER);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory with combinational read.
// Define DMEM_ARB_RR_EN for round-robin contention instead of port-0 priority with starvation relief.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
)
(
    input  logic              clk,
    input  logic              rstn,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataW,
    output logic              mem_isWmem,
    input  logic [DATA_W-1:0] mem_dataR
);

    arb_state_e        state;
    arb_state_e        state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              port_q;

    logic              winner;
    logic              any_gnt;
    logic              rd_done;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
    logic              rr_ptr;
`else
    localparam int     CNT_W = starve_cnt_w(STARVE_MAX);
    logic [CNT_W-1:0]  starve_cnt;
    logic              starve_hit;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
`endif

    dmem_arb_pick u_pick (
        .en         (rstn),
        .p0_req     (p0_req),
        .p1_req     (p1_req),
`ifdef DMEM_ARB_RR_EN
        .rr_ptr     (rr_ptr),
`else
        .starve_hit (starve_hit),
`endif
        .p0_gnt     (p0_gnt),
        .p1_gnt     (p1_gnt),
        .winner     (winner)
    );

    assign any_gnt   = p0_gnt || p1_gnt;
    assign sel_we    = (winner == PORT_LOADER) ? p1_we    : p0_we;
    assign sel_addr  = (winner == PORT_LOADER) ? p1_addr  : p0_addr;
    assign sel_wdata = (winner == PORT_LOADER) ? p1_wdata : p0_wdata;

    assign mem_address = addr_q;
    assign mem_dataW   = wdata_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            port_q  <= PORT_CORE;
        end else begin
            state <= state_nxt;
            if (any_gnt) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                we_q    <= sel_we;
                port_q  <= winner;
            end
        end
    end

    // Gating the write strobe with rstn drops a granted write if reset lands in its memory cycle.
    always_comb begin
        state_nxt  = state;
        mem_isWmem = 1'b0;
        rd_done    = 1'b0;
        case (state)
            IDLE: begin
                if (any_gnt) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_isWmem = we_q && rstn;
                rd_done    = !we_q;
                if (!any_gnt) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= rd_done && (port_q == PORT_CORE);
            p1_rvalid <= rd_done && (port_q == PORT_LOADER);
            if (rd_done && (port_q == PORT_CORE)) begin
                p0_rdata <= mem_dataR;
            end
            if (rd_done && (port_q == PORT_LOADER)) begin
                p1_rdata <= mem_dataR;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Only contested grants move the pointer, so an uncontested port cannot bank priority.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr <= PORT_CORE;
        end else if (p0_req && p1_req) begin
            rr_ptr <= ~winner;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (p1_gnt || !p1_req) begin
            starve_cnt <= '0;
        end else if (p0_gnt && !starve_hit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle grant model plus a read-data scoreboard.
// Works with or without DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              p0_req = 1'b0, p0_we = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0;
    logic              p0_gnt, p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p1_req = 1'b0, p1_we = 1'b0;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [DATA_W-1:0] p1_wdata = '0;
    logic              p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_dataW;
    logic              mem_isWmem;
    logic [DATA_W-1:0] mem_dataR;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rstn(rstn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_dataW(mem_dataW), .mem_isWmem(mem_isWmem),
        .mem_dataR(mem_dataR)
    );

    // Sixteen-word data memory behind the arbiter; loadMem seeds it once at start-up.
    logic              loadMem = 1'b1;
    logic [DATA_W-1:0] tbMem [0:15];
    assign mem_dataR = tbMem[mem_address[3:0]];

    always @(posedge clk) begin
        if (loadMem) begin
            for (int i = 0; i < 16; i++) tbMem[i] <= DATA_W'(32'h1000 + i);
        end else if (mem_isWmem) begin
            tbMem[mem_address[3:0]] <= mem_dataW;
        end
    end

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] data;
        int                due;
    } rd_t;

    rd_t               rdQ[$];
    logic [DATA_W-1:0] shadow [0:15];
    int                compareCount = 0;
    int                mismatchCount = 0;
    int                cyc = 0;
    bit                checkRegs = 0;

    logic              prevValid = 0, prevWe = 0, prevPort = 0;
    logic [ADDR_W-1:0] prevAddr = '0, lastAddr = '0;
    logic [DATA_W-1:0] prevWdata = '0, lastWdata = '0;
    logic [DATA_W-1:0] held0 = '0, held1 = '0;
    int                cnt = 0;
    logic              ptr = 0;
    logic              lastEg0 = 0, lastEg1 = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic p1WinsContention();
`ifdef DMEM_ARB_RR_EN
        return ptr;
`else
        return (cnt == STARVE_MAX);
`endif
    endfunction

    // One clock cycle: drive inputs, predict, check mid-cycle, then advance the model.
    task automatic applyStimulus(input logic rn,
                                 input logic r0, input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                 input logic r1, input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        logic expWmem, expRv0, expRv1, eg0, eg1;
        rstn = rn;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;

        expWmem = prevValid && prevWe && rn;
        expRv0 = 1'b0;
        expRv1 = 1'b0;
        if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
            if (rdQ[0].port) begin expRv1 = 1'b1; held1 = rdQ[0].data; end
            else             begin expRv0 = 1'b1; held0 = rdQ[0].data; end
            void'(rdQ.pop_front());
        end

        eg0 = 1'b0;
        eg1 = 1'b0;
        if (rn) begin
            if (r0 && r1) begin
                if (p1WinsContention()) eg1 = 1'b1;
                else                    eg0 = 1'b1;
            end else begin
                eg0 = r0;
                eg1 = r1;
            end
        end

        @(negedge clk);
        checkOutput("p0_gnt", 64'(p0_gnt), 64'(eg0));
        checkOutput("p1_gnt", 64'(p1_gnt), 64'(eg1));
        if (checkRegs) begin
            checkOutput("mem_isWmem", 64'(mem_isWmem), 64'(expWmem));
            checkOutput("mem_address", 64'(mem_address), 64'(lastAddr));
            checkOutput("mem_dataW", 64'(mem_dataW), 64'(lastWdata));
            checkOutput("p0_rvalid", 64'(p0_rvalid), 64'(expRv0));
            checkOutput("p1_rvalid", 64'(p1_rvalid), 64'(expRv1));
            checkOutput("p0_rdata", 64'(p0_rdata), 64'(held0));
            checkOutput("p1_rdata", 64'(p1_rdata), 64'(held1));
        end

        if (rn) begin
            if (prevValid && !prevWe) rdQ.push_back('{prevPort, shadow[prevAddr[3:0]], cyc + 1});
            if (prevValid && prevWe)  shadow[prevAddr[3:0]] = prevWdata;
            if (eg1 || !r1)                     cnt = 0;
            else if (eg0 && cnt < STARVE_MAX)   cnt = cnt + 1;
            if (r0 && r1) ptr = eg0;
            prevValid = eg0 || eg1;
            if (prevValid) begin
                prevPort  = eg1;
                prevWe    = eg1 ? w1 : w0;
                prevAddr  = eg1 ? a1 : a0;
                prevWdata = eg1 ? d1 : d0;
                lastAddr  = prevAddr;
                lastWdata = prevWdata;
            end
        end else begin
            prevValid = 1'b0;
            prevWe    = 1'b0;
            lastAddr  = '0;
            lastWdata = '0;
            held0     = '0;
            held1     = '0;
            rdQ.delete();
            cnt       = 0;
            ptr       = 1'b0;
        end
        lastEg0 = eg0;
        lastEg1 = eg1;

        @(posedge clk);
        #1;
        cyc++;
        checkRegs = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    logic              pend0, pend1, pw0, pw1;
    logic [ADDR_W-1:0] pa0, pa1;
    logic [DATA_W-1:0] pd0, pd1;
    int                guard;

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = DATA_W'(32'h1000 + i);

        // Reset held two cycles with a pending core request.
        applyStimulus(0, 1, 0, 32'h4, '0, 0, 0, '0, '0);
        loadMem = 1'b0;
        applyStimulus(0, 1, 0, 32'h4, '0, 0, 0, '0, '0);
        idle(1);

        // Write then read-back on port 0.
        applyStimulus(1, 1, 1, 32'h9, 32'h1, 0, 0, '0, '0);
        applyStimulus(1, 1, 0, 32'h9, '0,    0, 0, '0, '0);
        idle(3);

        // Port 1 alone, back-to-back write/read.
        applyStimulus(1, 0, 0, '0, '0, 1, 1, 32'h5, 32'hCAFE);
        applyStimulus(1, 0, 0, '0, '0, 1, 0, 32'h5, '0);
        applyStimulus(1, 0, 0, '0, '0, 1, 0, 32'h2, '0);
        idle(3);

        // Continuous contention on reads.
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 0, 32'(i % 16), '0, 1, 0, 32'h5, '0);
        idle(3);

        // Loader write wins contention against a core read of the same word.
        guard = 0;
        do begin
            if (p1WinsContention()) applyStimulus(1, 1, 0, 32'h8, '0, 1, 1, 32'h8, 32'hDEAD);
            else                    applyStimulus(1, 1, 0, 32'h2, '0, 1, 1, 32'h8, 32'hDEAD);
            guard++;
        end while (!lastEg1 && guard < 10);
        applyStimulus(1, 1, 0, 32'h8, '0, 0, 0, '0, '0);
        idle(3);

        // Reversed order: core read wins, sees the old word, then the write lands.
        applyStimulus(1, 1, 0, 32'h8, '0, 1, 1, 32'h8, 32'hBEEF);
        applyStimulus(1, 0, 0, '0,    '0, 1, 1, 32'h8, 32'hBEEF);
        applyStimulus(1, 1, 0, 32'h8, '0, 0, 0, '0, '0);
        idle(3);

        // Reset right after a granted write, and after a granted read.
        applyStimulus(1, 1, 1, 32'h3, 32'h55, 0, 0, '0, '0);
        applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, '0);
        applyStimulus(1, 0, 0, '0, '0, 1, 0, 32'h3, '0);
        applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, '0);
        idle(2);
        checkOutput("mem_word_3", 64'(tbMem[3]), 64'(shadow[3]));
        applyStimulus(1, 1, 0, 32'h3, '0, 0, 0, '0, '0);
        idle(3);

        // Random traffic; each requester holds its request until granted.
        pend0 = 0; pend1 = 0;
        pw0 = 0; pw1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int i = 0; i < 60; i++) begin
            if (!pend0 && $urandom_range(3) != 0) begin
                pend0 = 1; pw0 = 1'($urandom_range(1)); pa0 = 32'($urandom_range(15)); pd0 = $urandom;
            end
            if (!pend1 && $urandom_range(3) != 0) begin
                pend1 = 1; pw1 = 1'($urandom_range(1)); pa1 = 32'($urandom_range(15)); pd1 = $urandom;
            end
            applyStimulus(1, pend0, pw0, pa0, pd0, pend1, pw1, pa1, pd1);
            if (lastEg0) pend0 = 0;
            if (lastEg1) pend1 = 0;
        end
        idle(4);

        for (int i = 0; i < 16; i++) checkOutput($sformatf("mem_word_%0d", i), 64'(tbMem[i]), 64'(shadow[i]));
        checkOutput("rd_queue_empty", 64'(rdQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive port-0 grants while port 1 waits.
REQ-004 SHALL have one clock and a synchronous, active-low reset; ports are clk and rstn.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  synchronous active-low reset.
REQ-007 p0_req  input  1  core load/store request; held until granted.
REQ-008 p0_we  input  1  port-0 write (1) / read (0).
REQ-009 p0_addr  input  ADDR_W  port-0 address.
REQ-010 p0_wdata  input  DATA_W  port-0 write data.
REQ-011 p0_gnt  output  1  port-0 request accepted this cycle.
REQ-012 p0_rvalid  output  1  port-0 read data valid.
REQ-013 p0_rdata  output  DATA_W  port-0 read data.
REQ-014 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata SHALL mirror REQ-007..013 for the loader/debug port.
REQ-015 mem_address  output  ADDR_W  to dataMem address.
REQ-016 mem_dataW  output  DATA_W  to dataMem dataW.
REQ-017 mem_isWmem  output  1  to dataMem isWmem.
REQ-018 mem_dataR  input  DATA_W  from dataMem dataR (combinational read).

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS; IDLE->ACCESS on any req, ACCESS->ACCESS on new req, ACCESS->IDLE on no req.
REQ-020 SHALL grant at most one port per cycle; gnt is combinational from req and arbitration state.
REQ-021 On grant in cycle N, SHALL register winner's addr/wdata/we and drive mem_* during cycle N+1.
REQ-022 Write: mem_isWmem SHALL be 1 only in cycle N+1; dataMem commits at end of N+1.
REQ-023 Read: px_rvalid SHALL pulse 1 in cycle N+2 with px_rdata = mem_dataR sampled at end of N+1.
REQ-024 Writes SHALL produce no rvalid.
REQ-025 Back-to-back grants SHALL be allowed every cycle (throughput 1 access/cycle).
REQ-026 Read after write to same address granted in consecutive cycles SHALL return the new data.
REQ-027 Idle cycles: mem_isWmem SHALL be 0; mem_address/mem_dataW hold last value.
REQ-028 Starvation counter (width clog2(STARVE_MAX+1)) SHALL count consecutive p0 grants while p1_req=1; at STARVE_MAX, p1 wins next contention and counter clears; counter clears on any p1 grant or p1_req=0.
REQ-029 px_rdata SHALL hold its value between rvalid pulses.

Reset
REQ-030 With rstn=0 at a clock edge: state IDLE, mem_isWmem=0, mem_address=0, mem_dataW=0, p0/p1_rvalid=0, p0/p1_rdata=0, starvation counter=0, round-robin pointer=port 0.
REQ-031 gnt outputs SHALL be 0 while rstn=0.
REQ-032 Reset mid-access SHALL drop any pending write (isWmem forced 0 the following cycle) and any pending rvalid.

Configuration
REQ-033 Macro DMEM_ARB_RR_EN defined: contention resolved round-robin, pointer toggles to the other port after each contested grant; starvation counter not built.
REQ-034 DMEM_ARB_RR_EN undefined: fixed priority port 0 with starvation rule REQ-028.

Structure
REQ-035 Shared package SHALL hold state enum (IDLE, ACCESS) and port-index constants PORT_CORE=0, PORT_LOADER=1.
REQ-036 One sub-module dmem_arb_pick (combinational winner selection incl. priority/pointer) is natural; FSM and registers stay in top.

Verification
REQ-037 Reset: rstn=0 two cycles with p0_req=1 -> gnt=0, mem_isWmem=0, rvalid=0.
REQ-038 p0 write addr 0x9 data 0x1, then p0 read 0x9 next cycle -> isWmem=1 one cycle, rvalid in N+2 with rdata=0x1.
REQ-039 Both ports request reads continuously (fixed priority, STARVE_MAX=4) -> p0 granted 4 cycles, p1 granted 5th, pattern repeats.
REQ-040 With DMEM_ARB_RR_EN, both request continuously -> grants alternate p0,p1,p0,p1.
REQ-041 p1 write 0x8/0xDEAD and p0 read 0x8 requested same cycle -> write commits first (if p1 wins) and read returns 0xDEAD; reversed order returns old value.
REQ-042 Assert rstn=0 in cycle after granting a write -> memory word unchanged, no rvalid.
